accumulator_cpu_ctrl: RTL and testbench

- Multi-cycle accumulator CPU control/datapath. It is the bus initiator for the single-port 16-bit main memory: it drives address, R/W and write data, and captures read data.
- Instruction word format: [15:8] opcode, [7:0] operand address or jump target.
- Memory responds on the falling CLK edge. This block launches on the rising edge and samples on the next rising edge, so every memory access takes exactly one cycle.

---
 rtl/accumulator_cpu_ctrl_if.sv | 17 +
 rtl/accumulator_cpu_ctrl.sv | 170 +++++++++++++++++
 tb/tb_accumulator_cpu_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accumulator_cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_cpu_ctrl_if
// Purpose  : Single-port 16-bit main memory bus. The CPU is the master and
//            drives address, R/W and write data; memory returns read data.
// Revision : 1.0  initial release
// ============================================================================
interface accumulator_cpu_ctrl_if;
  logic [7:0]  MEM_ADDR;
  logic        MEM_RW;
  logic [15:0] MEM_DOUT;
  logic [15:0] MEM_DIN;

  modport master (output MEM_ADDR, output MEM_RW, output MEM_DOUT, input MEM_DIN);
  modport slave  (input MEM_ADDR, input MEM_RW, input MEM_DOUT, output MEM_DIN);
endinterface
`default_nettype wire

// File: rtl/accumulator_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_cpu_ctrl
// Purpose  : Multi-cycle accumulator CPU control and datapath. Each memory
//            access is launched on one rising edge and its data is captured
//            on the next, since memory answers on the falling edge.
// Revision : 1.0  initial release
// ============================================================================
module accumulator_cpu_ctrl #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         MUL_BITS = 15
) (
  input  wire logic              CLK,
  input  wire logic              RST,
  accumulator_cpu_ctrl_if.master bus,
  output logic [15:0]            ACC_OUT,
  output logic [7:0]             PC_OUT,
  output logic                   HALTED
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_EXEC   = 3'd3,
    S_MEMWR  = 3'd4,
    S_MUL    = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [7:0] c_OP_STORE  = 8'h01;
  localparam logic [7:0] c_OP_LOAD   = 8'h02;
  localparam logic [7:0] c_OP_ADD    = 8'h03;
  localparam logic [7:0] c_OP_SUB    = 8'h04;
  localparam logic [7:0] c_OP_JMPGEZ = 8'h05;
  localparam logic [7:0] c_OP_JMP    = 8'h06;
  localparam logic [7:0] c_OP_HALT   = 8'h07;
  localparam logic [7:0] c_OP_MUL    = 8'h08;
  localparam logic [7:0] c_OP_AND    = 8'h09;
  localparam logic [7:0] c_OP_OR     = 8'h0A;
  localparam logic [7:0] c_OP_NOT    = 8'h0B;
  localparam logic [7:0] c_OP_SHR    = 8'h0D;
  localparam logic [7:0] c_OP_SHL    = 8'h0E;
  localparam logic [3:0] c_MUL_LAST  = 4'(MUL_BITS - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_mbr;
  logic [15:0] r_acc;
  logic [3:0]  r_mul_cnt;
  logic [14:0] r_prod;

  logic [7:0]  w_opcode;
  logic        w_jump;
  logic [7:0]  w_mem_addr;
  logic        w_mem_rw;
  logic [14:0] w_prod_next;
  logic        w_mul_sign;
  logic        w_mul_last;

  assign w_opcode   = r_ir[15:8];
  // JMPGEZ treats zero as non-negative, so only the sign bit matters
  assign w_jump     = (w_opcode == c_OP_JMP) ||
                      ((w_opcode == c_OP_JMPGEZ) && !r_acc[15]);
  assign w_mul_last = (r_mul_cnt == c_MUL_LAST);

  // Shift-add one multiplier bit per cycle; bits beyond the 15-bit magnitude drop out
  assign w_prod_next = r_prod + (r_mbr[r_mul_cnt] ? (r_acc[14:0] << r_mul_cnt) : 15'd0);
  // A zero magnitude never carries a negative sign
  assign w_mul_sign  = (r_acc[15] ^ r_mbr[15]) & (|w_prod_next);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  // Next-state decode and memory bus control
  always_comb begin
    w_state_next = r_state;
    w_mem_addr   = r_pc;
    w_mem_rw     = 1'b0;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          c_OP_STORE:                      w_state_next = S_MEMWR;
          c_OP_LOAD, c_OP_ADD, c_OP_SUB,
          c_OP_MUL, c_OP_AND, c_OP_OR:     w_state_next = S_MEMRD;
          c_OP_HALT:                       w_state_next = S_HALT;
          default:                         w_state_next = S_FETCH;
        endcase
      end
      S_MEMRD: begin
        w_mem_addr   = r_ir[7:0];
        w_state_next = (w_opcode == c_OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC:   w_state_next = S_FETCH;
      S_MEMWR: begin
        w_mem_addr   = r_ir[7:0];
        w_mem_rw     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MUL: begin
        w_mem_addr = r_ir[7:0];
        if (w_mul_last) w_state_next = S_FETCH;
      end
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Datapath registers; reset abandons any in-flight multiply or store
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc      <= PC_RESET;
      r_ir      <= 16'h0000;
      r_mbr     <= 16'h0000;
      r_acc     <= 16'h0000;
      r_mul_cnt <= 4'd0;
      r_prod    <= 15'd0;
    end else begin
      case (r_state)
        S_FETCH:  r_ir <= bus.MEM_DIN;
        S_DECODE: begin
          r_pc <= w_jump ? r_ir[7:0] : r_pc + 8'd1;
          case (w_opcode)
            c_OP_NOT: r_acc <= ~r_acc;
            c_OP_SHR: r_acc <= {1'b0, r_acc[15:1]};
            c_OP_SHL: r_acc <= {r_acc[14:0], 1'b0};
            default:  r_acc <= r_acc;
          endcase
        end
        S_MEMRD: begin
          r_mbr     <= bus.MEM_DIN;
          r_mul_cnt <= 4'd0;
          r_prod    <= 15'd0;
        end
        S_EXEC: begin
          case (w_opcode)
            c_OP_LOAD: r_acc <= r_mbr;
            c_OP_ADD:  r_acc <= r_acc + r_mbr;
            c_OP_SUB:  r_acc <= r_acc - r_mbr;
            c_OP_AND:  r_acc <= r_acc & r_mbr;
            c_OP_OR:   r_acc <= r_acc | r_mbr;
            default:   r_acc <= r_acc;
          endcase
        end
        S_MUL: begin
          r_prod    <= w_prod_next;
          r_mul_cnt <= r_mul_cnt + 4'd1;
          if (w_mul_last) r_acc <= {w_mul_sign, w_prod_next};
        end
        default: ;
      endcase
    end
  end

  assign bus.MEM_ADDR = w_mem_addr;
  // Write strobe drops the moment reset is asserted, not at the next edge
  assign bus.MEM_RW   = w_mem_rw & ~RST;
  assign bus.MEM_DOUT = r_acc;
  assign ACC_OUT      = r_acc;
  assign PC_OUT       = r_pc;
  assign HALTED       = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_accumulator_cpu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_cpu_ctrl
// Purpose  : Self-checking bench for accumulator_cpu_ctrl: a table of
//            single-instruction vectors plus hand-written program sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_accumulator_cpu_ctrl;

  logic CLK;
  logic RST;
  logic [15:0] ACC_OUT;
  logic [7:0]  PC_OUT;
  logic        HALTED;

  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  accumulator_cpu_ctrl_if u_bus ();

  accumulator_cpu_ctrl #(.PC_RESET(8'h00), .MUL_BITS(15)) u_dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (u_bus),
    .ACC_OUT (ACC_OUT),
    .PC_OUT  (PC_OUT),
    .HALTED  (HALTED)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: answers on the falling edge
  always @(negedge CLK) begin
    if (u_bus.MEM_RW) mem[u_bus.MEM_ADDR] = u_bus.MEM_DOUT;
    u_bus.MEM_DIN = mem[u_bus.MEM_ADDR];
  end

  typedef struct {
    logic [15:0] acc_init;
    logic [15:0] instr;
    logic [15:0] data;
    int          lat;
    logic [15:0] exp_acc;
    logic [7:0]  exp_pc;
    logic        exp_halt;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'h0700;
  endtask

  // Release reset on a falling edge; the next rising edge is cycle 1
  task automatic start_run();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic load_mul_prog();
    clear_mem();
    mem[8'h00] = 16'h060C;
    mem[8'h0C] = 16'h02A6;
    mem[8'h0D] = 16'h08A5;
    mem[8'h0E] = 16'h0E00;
    mem[8'h0F] = 16'h0E00;
    mem[8'h10] = 16'h0E00;
    mem[8'h11] = 16'h01A4;
    mem[8'hA4] = 16'hDEAD;
    mem[8'hA5] = 16'h8005;
    mem[8'hA6] = 16'h000F;
  endtask

  logic [7:0] exp_addr [7];
  logic       exp_rw   [7];

  initial begin
    RST = 1'b1;
    u_bus.MEM_DIN = 16'h0000;

    vecs[0]  = '{16'h0000, 16'h0280, 16'h1234,  4, 16'h1234, 8'h02, 1'b1, 16'h1234};
    vecs[1]  = '{16'h7FFF, 16'h0380, 16'h0001,  4, 16'h8000, 8'h02, 1'b1, 16'h0001};
    vecs[2]  = '{16'h0005, 16'h0480, 16'h0007,  4, 16'hFFFE, 8'h02, 1'b1, 16'h0007};
    vecs[3]  = '{16'hF0F0, 16'h0980, 16'h3C3C,  4, 16'h3030, 8'h02, 1'b1, 16'h3C3C};
    vecs[4]  = '{16'hF0F0, 16'h0A80, 16'h0F01,  4, 16'hFFF1, 8'h02, 1'b1, 16'h0F01};
    vecs[5]  = '{16'h1234, 16'h0B00, 16'h0000,  2, 16'hEDCB, 8'h02, 1'b1, 16'h0000};
    vecs[6]  = '{16'h8001, 16'h0D00, 16'h0000,  2, 16'h4000, 8'h02, 1'b1, 16'h0000};
    vecs[7]  = '{16'h8001, 16'h0E00, 16'h0000,  2, 16'h0002, 8'h02, 1'b1, 16'h0000};
    vecs[8]  = '{16'h0000, 16'h0540, 16'h0000,  2, 16'h0000, 8'h40, 1'b1, 16'h0000};
    vecs[9]  = '{16'h8000, 16'h0540, 16'h0000,  2, 16'h8000, 8'h02, 1'b1, 16'h0000};
    vecs[10] = '{16'h1111, 16'h0650, 16'h0000,  2, 16'h1111, 8'h50, 1'b1, 16'h0000};
    vecs[11] = '{16'h1111, 16'h0F00, 16'h0000,  2, 16'h1111, 8'h02, 1'b1, 16'h0000};
    vecs[12] = '{16'h000F, 16'h0880, 16'h8005, 18, 16'h804B, 8'h02, 1'b1, 16'h8005};
    vecs[13] = '{16'h8003, 16'h0880, 16'h8004, 18, 16'h000C, 8'h02, 1'b1, 16'h8004};
    vecs[14] = '{16'h8000, 16'h0880, 16'h0005, 18, 16'h0000, 8'h02, 1'b1, 16'h0005};
    vecs[15] = '{16'h4000, 16'h0880, 16'h0002, 18, 16'h0000, 8'h02, 1'b1, 16'h0002};
    vecs[16] = '{16'h7FFF, 16'h0880, 16'h7FFF, 18, 16'h0001, 8'h02, 1'b1, 16'h7FFF};
    vecs[17] = '{16'hFFFF, 16'h0D00, 16'h0000,  2, 16'h7FFF, 8'h02, 1'b1, 16'h0000};
    vecs[18] = '{16'h5A5A, 16'h0180, 16'h0000,  3, 16'h5A5A, 8'h02, 1'b1, 16'h5A5A};
    vecs[19] = '{16'h2222, 16'h0601, 16'h0000,  2, 16'h2222, 8'h01, 1'b0, 16'h0000};

    // Reset and first fetch
    clear_mem();
    tick(1);
    chk("rst rw held", {15'd0, u_bus.MEM_RW}, 16'h0000);
    start_run();
    #1;
    chk("rst pc", {8'h00, PC_OUT}, 16'h0000);
    chk("rst acc", ACC_OUT, 16'h0000);
    chk("rst halted", {15'd0, HALTED}, 16'h0000);
    chk("rst rw", {15'd0, u_bus.MEM_RW}, 16'h0000);
    chk("rst addr", {8'h00, u_bus.MEM_ADDR}, 16'h0000);

    // Single-instruction vectors: LOAD F0 seeds ACC, then the instruction under test
    for (int i = 0; i < 20; i++) begin
      RST = 1'b1;
      clear_mem();
      mem[8'h00] = 16'h02F0;
      mem[8'h01] = vecs[i].instr;
      mem[8'hF0] = vecs[i].acc_init;
      mem[8'h80] = vecs[i].data;
      start_run();
      tick(4 + vecs[i].lat);
      chk($sformatf("v%0d acc", i), ACC_OUT, vecs[i].exp_acc);
      chk($sformatf("v%0d pc", i), {8'h00, PC_OUT}, {8'h00, vecs[i].exp_pc});
      chk($sformatf("v%0d fetch addr", i), {8'h00, u_bus.MEM_ADDR}, {8'h00, vecs[i].exp_pc});
      chk($sformatf("v%0d halted early", i), {15'd0, HALTED}, 16'h0000);
      tick(2);
      chk($sformatf("v%0d halted", i), {15'd0, HALTED}, {15'd0, vecs[i].exp_halt});
      chk($sformatf("v%0d mem80", i), mem[8'h80], vecs[i].exp_mem);
    end

    // LOAD/STORE bus timing
    RST = 1'b1;
    clear_mem();
    mem[8'h00] = 16'h02A0;
    mem[8'h01] = 16'h01A4;
    mem[8'hA0] = 16'h1234;
    exp_addr = '{8'h00, 8'h00, 8'hA0, 8'h01, 8'h01, 8'h01, 8'hA4};
    exp_rw   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_run();
    #1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("ls addr c%0d", k), {8'h00, u_bus.MEM_ADDR}, {8'h00, exp_addr[k]});
      chk($sformatf("ls rw c%0d", k), {15'd0, u_bus.MEM_RW}, {15'd0, exp_rw[k]});
      tick(1);
    end
    chk("ls rw after", {15'd0, u_bus.MEM_RW}, 16'h0000);
    chk("ls memA4", mem[8'hA4], 16'h1234);

    // Summation loop: A4 = 5+4+3+2+1+0, A3 counts down past zero
    RST = 1'b1;
    clear_mem();
    mem[8'h00] = 16'h02A0; mem[8'h01] = 16'h01A3; mem[8'h02] = 16'h02A2;
    mem[8'h03] = 16'h01A4; mem[8'h04] = 16'h02A4; mem[8'h05] = 16'h03A3;
    mem[8'h06] = 16'h01A4; mem[8'h07] = 16'h02A3; mem[8'h08] = 16'h04A1;
    mem[8'h09] = 16'h01A3; mem[8'h0A] = 16'h0504;
    mem[8'hA0] = 16'h0005; mem[8'hA1] = 16'h0001; mem[8'hA2] = 16'h0000;
    start_run();
    begin
      int cyc = 0;
      while (!HALTED && cyc < 3000) begin
        tick(1);
        cyc++;
      end
    end
    chk("sum halted", {15'd0, HALTED}, 16'h0001);
    chk("sum A4", mem[8'hA4], 16'h000F);
    chk("sum A3", mem[8'hA3], 16'hFFFF);

    // MUL then shifts, store and halt
    RST = 1'b1;
    load_mul_prog();
    start_run();
    tick(23);
    chk("mul acc c23", ACC_OUT, 16'h000F);
    tick(1);
    chk("mul acc c24", ACC_OUT, 16'h804B);
    tick(6);
    chk("shl acc", ACC_OUT, 16'h0258);
    tick(3);
    chk("store A4", mem[8'hA4], 16'h0258);
    tick(2);
    chk("halt halted", {15'd0, HALTED}, 16'h0001);
    chk("halt pc", {8'h00, PC_OUT}, 16'h0013);
    tick(5);
    chk("halt pc frozen", {8'h00, PC_OUT}, 16'h0013);
    chk("halt acc frozen", ACC_OUT, 16'h0258);

    // Reset during MUL iteration 7, then during MEMWR, then full rerun
    RST = 1'b1;
    load_mul_prog();
    start_run();
    tick(15);
    chk("mid mul acc", ACC_OUT, 16'h000F);
    RST = 1'b1;
    #1;
    chk("mid mul rst acc", ACC_OUT, 16'h0000);
    chk("mid mul rst pc", {8'h00, PC_OUT}, 16'h0000);
    chk("mid mul rst addr", {8'h00, u_bus.MEM_ADDR}, 16'h0000);
    chk("mid mul rst rw", {15'd0, u_bus.MEM_RW}, 16'h0000);
    start_run();
    tick(24);
    chk("rerun mul acc", ACC_OUT, 16'h804B);
    tick(8);
    chk("memwr rw", {15'd0, u_bus.MEM_RW}, 16'h0001);
    chk("memwr addr", {8'h00, u_bus.MEM_ADDR}, 16'h00A4);
    RST = 1'b1;
    #1;
    chk("memwr rst rw", {15'd0, u_bus.MEM_RW}, 16'h0000);
    tick(1);
    chk("memwr no write", mem[8'hA4], 16'hDEAD);
    start_run();
    tick(35);
    chk("rerun halted", {15'd0, HALTED}, 16'h0001);
    chk("rerun A4", mem[8'hA4], 16'h0258);

    // PC wrap FF -> 00
    RST = 1'b1;
    clear_mem();
    mem[8'h00] = 16'h06FF;
    mem[8'hFF] = 16'h0000;
    start_run();
    tick(2);
    chk("wrap pc FF", {8'h00, PC_OUT}, 16'h00FF);
    tick(2);
    chk("wrap pc 00", {8'h00, PC_OUT}, 16'h0000);
    chk("wrap addr", {8'h00, u_bus.MEM_ADDR}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
